// File: rtl/bus_mem_pkg.sv
// Shared types and opcode constants for the external bus transaction sequencer.
package bus_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } bus_state_t;

    localparam logic [2:0] OP_LEER    = 3'b011;
    localparam logic [2:0] OP_ESC_IMM = 3'b101;
    localparam logic [2:0] OP_ESC_REG = 3'b110;

    localparam int CNT_W = 8;

    function automatic logic op_valid(input logic [2:0] op);
        return (op == OP_LEER) || (op == OP_ESC_IMM) || (op == OP_ESC_REG);
    endfunction

endpackage

// File: rtl/bus_wait_cnt.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module bus_wait_cnt
    import bus_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             cnt_zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/bus_mem_ctrl.sv
// One external 8-bit bus transaction per decoder command: setup, strobe until ACK, hold.
// Optional strobe timeout is compiled in with `define BUS_TIMEOUT_EN.
module bus_mem_ctrl
    import bus_mem_pkg::*;
#(
    parameter int SETUP_CYC   = 1,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic [2:0] SELEC,
    input  logic [7:0] RX_DATO,
    input  logic [2:0] RY,
    input  logic [7:0] RY_DATO,
    input  logic [7:0] DATO_IN,
    input  logic       ACK,
    output logic [7:0] DIR_OUT,
    output logic [7:0] DATO_OUT,
    output logic       RD,
    output logic       WR,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] DATO_LEIDO,
    output logic       BAD_OP,
    output logic       TIMEOUT
);

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);

    bus_state_t       state, state_nxt;
    logic             cnt_load, cnt_en, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic             start_ok, bad_cmd;
    logic             rd_op_q, bad_op_q;
    logic [7:0]       dir_q, dato_q, leido_q;
`ifdef BUS_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYC - 1);
    logic             to_hit, to_q;
`endif

    // The same counter times the setup phase and, when enabled, the strobe timeout.
    bus_wait_cnt u_wait_cnt (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .cnt_zero (cnt_zero)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_en    = 1'b0;
        start_ok  = 1'b0;
        bad_cmd   = 1'b0;
`ifdef BUS_TIMEOUT_EN
        to_hit    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (START) begin
                    if (op_valid(SELEC)) begin
                        start_ok  = 1'b1;
                        cnt_load  = 1'b1;
                        cnt_val   = SETUP_LOAD;
                        state_nxt = SETUP;
                    end else begin
                        bad_cmd = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_nxt = STROBE;
`ifdef BUS_TIMEOUT_EN
                    cnt_load  = 1'b1;
                    cnt_val   = TIMEOUT_LOAD;
`endif
                end else begin
                    cnt_en = 1'b1;
                end
            end
            STROBE: begin
                // ACK is checked first so it wins over a simultaneous expiry.
                if (ACK) begin
                    state_nxt = HOLD;
`ifdef BUS_TIMEOUT_EN
                end else if (cnt_zero) begin
                    state_nxt = HOLD;
                    to_hit    = 1'b1;
                end else begin
                    cnt_en = 1'b1;
`endif
                end
            end
            HOLD: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_op_q  <= 1'b0;
            dir_q    <= '0;
            dato_q   <= '0;
            leido_q  <= '0;
            bad_op_q <= 1'b0;
        end else begin
            bad_op_q <= bad_cmd;
            if (start_ok) begin
                rd_op_q <= (SELEC == OP_LEER);
                case (SELEC)
                    OP_LEER:    begin dir_q <= RY_DATO; dato_q <= '0;          end
                    OP_ESC_IMM: begin dir_q <= RX_DATO; dato_q <= {5'b0, RY};  end
                    default:    begin dir_q <= RX_DATO; dato_q <= RY_DATO;     end
                endcase
            end else if (state == HOLD) begin
                dir_q  <= '0;
                dato_q <= '0;
            end
            if ((state == STROBE) && ACK && rd_op_q) begin
                leido_q <= DATO_IN;
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            to_q <= 1'b0;
        end else begin
            to_q <= to_hit;
        end
    end
    assign TIMEOUT = to_q;
`else
    assign TIMEOUT = 1'b0;
`endif

    assign DIR_OUT    = dir_q;
    assign DATO_OUT   = dato_q;
    assign RD         = (state == STROBE) && rd_op_q;
    assign WR         = (state == STROBE) && !rd_op_q;
    assign BUSY       = (state != IDLE);
    assign DONE       = (state == HOLD);
    assign DATO_LEIDO = leido_q;
    assign BAD_OP     = bad_op_q;

endmodule

// File: doc/bus_mem_ctrl.md
Name: bus_mem_ctrl

Overview:
Sequences one external memory/IO bus transaction per command from the instruction decoder. It latches the SELEC opcode and its operands, drives the address and data buses through setup, strobe and hold phases, and waits for a slave ACK. It returns read data and a one-cycle DONE, and sits between the decoder/register file and the 8-bit external bus.

Parameters:
SETUP_CYC, 1, cycles address/data are stable before the strobe (min 1, max 15)
TIMEOUT_CYC, 16, strobe cycles without ACK before abort (used only with BUS_TIMEOUT_EN; min 1, max 255)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  command valid; sampled only in IDLE
SELEC  in  3  opcode: 3'b011 read @RY_DATO; 3'b101 write {5'b0,RY} @RX_DATO; 3'b110 write RY_DATO @RX_DATO
RX_DATO  in  8  register X contents
RY  in  3  register Y index, used as a 3-bit immediate
RY_DATO  in  8  register Y contents
DATO_IN  in  8  read data from slave
ACK  in  1  slave acknowledge
DIR_OUT  out  8  bus address (registered)
DATO_OUT  out  8  bus write data (registered)
RD  out  1  read strobe
WR  out  1  write strobe
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse ending a transaction
DATO_LEIDO  out  8  last successfully read byte
BAD_OP  out  1  one-cycle pulse when START arrives with an unsupported SELEC
TIMEOUT  out  1  one-cycle pulse with DONE on abort (tied 0 without BUS_TIMEOUT_EN)

Behaviour:
- Reset (async, RST_N=0) forces every output to 0 and the FSM to IDLE immediately. This includes reset in the middle of a transaction: strobes drop at once and no DONE is produced.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE: DIR_OUT=0, DATO_OUT=0, RD=WR=0.
  - START=1 with a valid SELEC: latch the opcode, address and data, load the setup counter with SETUP_CYC-1, then go to SETUP.
  - START=1 with any other SELEC: pulse BAD_OP for 1 cycle and stay in IDLE.
- Address/data for each opcode:
  - 011: DIR_OUT=RY_DATO, DATO_OUT=0.
  - 101: DIR_OUT=RX_DATO, DATO_OUT={5'b0,RY}.
  - 110: DIR_OUT=RX_DATO, DATO_OUT=RY_DATO.
- SETUP: DIR_OUT/DATO_OUT driven and stable, strobes low. Lasts exactly SETUP_CYC cycles, then go to STROBE.
- STROBE: RD=1 for a read, WR=1 for a write. On the first cycle ACK=1 is sampled:
  - a read captures DATO_IN into DATO_LEIDO on that edge;
  - go to HOLD.
  - ACK is ignored in every other state.
- HOLD: strobes low, DIR_OUT/DATO_OUT still held, DONE=1 for this single cycle, then go to IDLE.
- START while BUSY is ignored; it is neither queued nor flagged.
- Operands are latched at START. Changes to RX_DATO/RY/RY_DATO during a transaction have no effect.
- Latency with SETUP_CYC=1 and ACK tied high: START sampled at edge 0 → SETUP in cycle 1 → STROBE in cycle 2 → HOLD/DONE in cycle 3 → IDLE in cycle 4.
- Back-to-back: START may be accepted in the first IDLE cycle after HOLD.
- DATO_LEIDO changes only on a read ACK; writes leave it unchanged.

Optional Feature:
BUS_TIMEOUT_EN:
- Defined: an 8-bit counter runs in STROBE. If ACK has not been seen after TIMEOUT_CYC strobe cycles, the strobe drops and the FSM goes to HOLD with DONE=1 and TIMEOUT=1. DATO_LEIDO is not updated. ACK on the same cycle as expiry wins; there is no TIMEOUT in that case.
- Undefined: STROBE waits for ACK indefinitely, TIMEOUT is tied to 0, and the counter is absent.

Decomposition:
- Package bus_mem_pkg holds:
  - state enum (IDLE, SETUP, STROBE, HOLD);
  - opcode constants OP_LEER=3'b011, OP_ESC_IMM=3'b101, OP_ESC_REG=3'b110;
  - an opcode-valid function.
- One sub-module, bus_wait_cnt: loadable down-counter with a zero flag. It is shared for the setup count and the timeout count.

Test Plan:
- SELEC=011, RY_DATO=8'h3C, DATO_IN=8'hA5, ACK high after 2 strobe cycles → DIR_OUT=3C, RD high for 3 cycles, DATO_LEIDO=A5, DONE single pulse, BUSY low afterwards.
- SELEC=101, RX_DATO=8'h10, RY=3'b110, ACK tied 1, SETUP_CYC=1 → DIR_OUT=10, DATO_OUT=06, WR high for exactly 1 cycle, DONE 3 cycles after START.
- SELEC=110 with RX_DATO=8'hF0, RY_DATO=8'h55; operands changed and START re-pulsed mid-transaction → bus still shows F0/55, exactly one DONE.
- SELEC=000 with START → BAD_OP 1 cycle, BUSY stays 0, bus outputs stay 0.
- RST_N pulled low during STROBE of a write → RD/WR/DIR_OUT/DATO_OUT/BUSY go to 0 asynchronously; no DONE after release.
- BUS_TIMEOUT_EN, TIMEOUT_CYC=4, ACK never asserted → WR drops after 4 cycles, DONE=TIMEOUT=1 together, DATO_LEIDO unchanged.
